remote_cmd_tx: RTL and testbench

//  Host-side end of the BLE/UART command link. Serializes 16-bit Knight commands as two 8N1 UART

---
 rtl/remote_pkg.sv | 10 +
 rtl/remote_cmd_tx_if.sv | 24 ++
 rtl/remote_uart_tx.sv | 61 ++++++
 rtl/remote_cmd_tx.sv | 185 ++++++++++++++++++
 tb/tb_remote_cmd_tx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_pkg.sv
// Shared state type and link constants for the host-side remote command link.
package remote_pkg;

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} remote_state_e;

  localparam logic [7:0]  RESP_DONE = 8'hA5;
  localparam logic [7:0]  RESP_PROG = 8'h5A;
  localparam int unsigned FRAME_LEN = 10;

endpackage

// File: rtl/remote_cmd_tx_if.sv
// Command/response handshake between a host controller and remote_cmd_tx.
interface remote_cmd_tx_if;

  logic        snd_cmd;
  logic [15:0] cmd;
  logic        busy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        done;
  logic        resp_err;
  logic        tmo;

  modport master (
    output snd_cmd, cmd,
    input  busy, cmd_snt, resp, resp_rdy, done, resp_err, tmo
  );

  modport slave (
    input  snd_cmd, cmd,
    output busy, cmd_snt, resp, resp_rdy, done, resp_err, tmo
  );

endinterface

// File: rtl/remote_uart_tx.sv
// 8N1 byte serializer; a trmt on the tx_done cycle chains the next frame with no gap.
module remote_uart_tx #(
  parameter int unsigned BAUD_CYC = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);
  import remote_pkg::*;

  localparam int unsigned CntW = $clog2(BAUD_CYC);

  logic            busy_q, busy_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      shift_q, shift_d;

  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_done = busy_q && (baud_q == CntW'(BAUD_CYC - 1)) && (bit_q == 4'(FRAME_LEN - 1));
    if (busy_q) begin
      if (baud_q == CntW'(BAUD_CYC - 1)) begin
        baud_d  = '0;
        bit_d   = bit_q + 4'd1;
        shift_d = {1'b1, shift_q[9:1]};
        if (tx_done) busy_d = 1'b0;
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
    if (trmt) begin
      busy_d  = 1'b1;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = {1'b1, tx_data, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign TX = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/remote_cmd_tx.sv
// Host end of the remote command link: sends a 16-bit command, then tracks the robot's reply.
// Optional response timeout enabled by defining REMOTE_TMO_EN.
module remote_cmd_tx #(
  parameter int unsigned BAUD_CYC = 2604,
  parameter int unsigned TMO_CYC  = 2 ** 24
) (
  input  logic            clk,
  input  logic            rst,
  output logic            TX,
  input  logic            RX,
  remote_cmd_tx_if.slave  bus
);
  import remote_pkg::*;

  localparam int unsigned CntW = $clog2(BAUD_CYC);

  if (BAUD_CYC < 4 || (BAUD_CYC % 2) != 0 || TMO_CYC < 2) begin : g_param_check
    $error("remote_cmd_tx: BAUD_CYC must be even and >= 4, TMO_CYC >= 2");
  end

  remote_state_e state_q, state_d;
  logic [7:0]    cmd_lo_q, cmd_lo_d;
  logic          trmt, tx_done;
  logic [7:0]    tx_data;
  logic          cmd_snt_q, cmd_snt_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, done_q, done_d, resp_err_q, resp_err_d;
  logic          tmo_pulse;

  remote_uart_tx #(.BAUD_CYC(BAUD_CYC)) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

  always_comb begin
    state_d   = state_q;
    cmd_lo_d  = cmd_lo_q;
    trmt      = 1'b0;
    tx_data   = cmd_lo_q;
    cmd_snt_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.snd_cmd) begin
        state_d  = TX_HI;
        cmd_lo_d = bus.cmd[7:0];
        trmt     = 1'b1;
        tx_data  = bus.cmd[15:8];
      end
      TX_HI: if (tx_done) begin
        state_d = TX_LO;
        trmt    = 1'b1;
      end
      TX_LO: if (tx_done) begin
        state_d   = WAIT_RESP;
        cmd_snt_d = 1'b1;
      end
      WAIT_RESP: if (done_q || resp_err_q || tmo_pulse) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Receiver: 2-flop sync, falling-edge start, half-bit start recheck, centre sampling.
  logic [1:0]      rx_sync_q;
  logic            rx_prev_q, rx_s, rx_fall;
  logic            rx_act_q, rx_act_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_done, frame_err, in_wait;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

  always_comb begin
    rx_act_d   = rx_act_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    if (!rx_act_q) begin
      if (rx_fall) begin
        rx_act_d = 1'b1;
        rx_cnt_d = CntW'(BAUD_CYC / 2 - 1);
        rx_bit_d = '0;
      end
    end else if (rx_cnt_q == '0) begin
      rx_cnt_d = CntW'(BAUD_CYC - 1);
      rx_bit_d = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0) begin
        if (rx_s) rx_act_d = 1'b0;
      end else if (rx_bit_q < 4'(FRAME_LEN - 1)) begin
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
      end else begin
        rx_act_d  = 1'b0;
        byte_done = 1'b1;
        frame_err = ~rx_s;
      end
    end else begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end
  end

  // A byte finishing on the cmd_snt cycle is judged as if already in WAIT_RESP.
  assign in_wait    = (state_q == WAIT_RESP) || cmd_snt_d;
  assign resp_d     = byte_done ? rx_shift_q : resp_q;
  assign done_d     = byte_done && in_wait && !frame_err && (rx_shift_q == RESP_DONE);
  assign resp_err_d = byte_done && in_wait &&
                      (frame_err || (rx_shift_q != RESP_DONE && rx_shift_q != RESP_PROG));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_lo_q   <= '0;
      cmd_snt_q  <= 1'b0;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_act_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_lo_q   <= cmd_lo_d;
      cmd_snt_q  <= cmd_snt_d;
      resp_q     <= resp_d;
      resp_rdy_q <= byte_done;
      done_q     <= done_d;
      resp_err_q <= resp_err_d;
      rx_sync_q  <= {rx_sync_q[0], RX};
      rx_prev_q  <= rx_s;
      rx_act_q   <= rx_act_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

`ifdef REMOTE_TMO_EN
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_q, tmo_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    tmo_d     = 1'b0;
    if (state_q != WAIT_RESP || resp_rdy_q) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TmoW'(TMO_CYC - 1)) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo_pulse = tmo_q;
`else
  assign tmo_pulse = 1'b0;
`endif

  assign bus.busy     = (state_q != IDLE);
  assign bus.cmd_snt  = cmd_snt_q;
  assign bus.resp     = resp_q;
  assign bus.resp_rdy = resp_rdy_q;
  assign bus.done     = done_q;
  assign bus.resp_err = resp_err_q;
  assign bus.tmo      = tmo_pulse;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Directed bench for remote_cmd_tx at BAUD_CYC=16, TMO_CYC=1000.
module tb_remote_cmd_tx;
  localparam int unsigned Baud = 16;
  localparam int unsigned Tmo  = 1000;

  logic clk = 1'b0;
  logic rst, RX, TX;
  int   checks = 0;
  int   errors = 0;

  remote_cmd_tx_if cmd_if ();

  remote_cmd_tx #(.BAUD_CYC(Baud), .TMO_CYC(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .TX  (TX),
    .RX  (RX),
    .bus (cmd_if)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  int         rdy_cnt, done_cnt, err_cnt, tmo_cnt;
  logic [7:0] done_resp, err_resp;
  logic       busy_at_evt, busy_after_evt, evt_prev;

  always @(negedge clk) begin
    if (evt_prev) busy_after_evt = cmd_if.busy;
    if (cmd_if.resp_rdy) rdy_cnt++;
    if (cmd_if.done) begin
      done_cnt++; done_resp = cmd_if.resp; busy_at_evt = cmd_if.busy;
    end
    if (cmd_if.resp_err) begin
      err_cnt++; err_resp = cmd_if.resp; busy_at_evt = cmd_if.busy;
    end
    if (cmd_if.tmo) begin
      tmo_cnt++; busy_at_evt = cmd_if.busy;
    end
    evt_prev = cmd_if.done | cmd_if.resp_err | cmd_if.tmo;
  end

  task automatic clear_mon();
    rdy_cnt = 0; done_cnt = 0; err_cnt = 0; tmo_cnt = 0;
    done_resp = 8'h00; err_resp = 8'h00;
    busy_at_evt = 1'b0; busy_after_evt = 1'b1;
  endtask

  // Launch a command and capture the 20 TX bits at their centres; returns on cmd_snt.
  task automatic send_cmd(input logic [15:0] v, input bit inject, output logic [7:0] hi,
                          output logic [7:0] lo, output int lat, output bit busy_ok,
                          output bit frame_ok);
    logic [19:0] bits;
    int c;
    bits = '0; c = 0; lat = -1; busy_ok = 1'b1;
    @(negedge clk);
    cmd_if.snd_cmd = 1'b1; cmd_if.cmd = v;
    while (c < 340 && lat < 0) begin
      @(negedge clk);
      if (c == 0) cmd_if.snd_cmd = 1'b0;
      if (inject && c == 40) begin cmd_if.snd_cmd = 1'b1; cmd_if.cmd = 16'hFFFF; end
      if (inject && c == 41) cmd_if.snd_cmd = 1'b0;
      if (c < 320 && (c % 16) == 8) bits[c/16] = TX;
      if (c < 320 && !cmd_if.busy) busy_ok = 1'b0;
      if (cmd_if.cmd_snt) lat = c;
      c++;
    end
    hi = bits[8:1];
    lo = bits[18:11];
    frame_ok = !bits[0] && bits[9] && !bits[10] && bits[19];
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (Baud) @(negedge clk);
    end
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; RX = 1'b1; cmd_if.snd_cmd = 1'b0; cmd_if.cmd = '0;
    clear_mon(); evt_prev = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", TX); end
    checks++; if (cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", cmd_if.busy);
    end
    checks++; if (cmd_if.resp !== 8'h00) begin
      errors++; $display("FAIL reset_resp got %h want 00", cmd_if.resp);
    end
    checks++;
    if ({cmd_if.cmd_snt, cmd_if.resp_rdy, cmd_if.done, cmd_if.resp_err, cmd_if.tmo} !== 5'b0)
    begin
      errors++; $display("FAIL reset_pulses got %b want 00000",
        {cmd_if.cmd_snt, cmd_if.resp_rdy, cmd_if.done, cmd_if.resp_err, cmd_if.tmo});
    end
  endtask

  task automatic test_cmd_frame();
    logic [7:0] hi, lo; int lat; bit bok, fok;
    send_cmd(16'h2345, 1'b0, hi, lo, lat, bok, fok);
    checks++; if (hi !== 8'h23) begin errors++; $display("FAIL frame_hi got %h want 23", hi); end
    checks++; if (lo !== 8'h45) begin errors++; $display("FAIL frame_lo got %h want 45", lo); end
    checks++; if (!fok) begin errors++; $display("FAIL frame_start_stop got 0 want 1"); end
    checks++; if (lat != 320) begin errors++; $display("FAIL cmd_snt_lat got %0d want 320", lat); end
    checks++; if (!bok) begin errors++; $display("FAIL frame_busy got 0 want 1"); end
  endtask

  task automatic test_responses();
    clear_mon();
    send_byte(8'h5A, 1'b1);
    checks++; if (rdy_cnt != 1) begin errors++; $display("FAIL prog_rdy got %0d want 1", rdy_cnt); end
    checks++; if (cmd_if.resp !== 8'h5A) begin
      errors++; $display("FAIL prog_resp got %h want 5a", cmd_if.resp);
    end
    checks++; if (cmd_if.busy !== 1'b1) begin
      errors++; $display("FAIL prog_busy got %b want 1", cmd_if.busy);
    end
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    checks++; if (rdy_cnt != 3) begin errors++; $display("FAIL resp_rdy_cnt got %0d want 3", rdy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_cnt got %0d want 1", done_cnt); end
    checks++; if (done_resp !== 8'hA5) begin
      errors++; $display("FAIL done_resp got %h want a5", done_resp);
    end
    checks++; if (busy_at_evt !== 1'b1) begin
      errors++; $display("FAIL busy_at_done got %b want 1", busy_at_evt);
    end
    checks++; if (busy_after_evt !== 1'b0) begin
      errors++; $display("FAIL busy_after_done got %b want 0", busy_after_evt);
    end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL good_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_bad_resp();
    logic [7:0] hi, lo; int lat; bit bok, fok;
    send_cmd(16'h2345, 1'b0, hi, lo, lat, bok, fok);
    clear_mon();
    send_byte(8'h11, 1'b1);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL bad_err_cnt got %0d want 1", err_cnt); end
    checks++; if (err_resp !== 8'h11) begin
      errors++; $display("FAIL bad_err_resp got %h want 11", err_resp);
    end
    checks++; if (cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL bad_busy got %b want 0", cmd_if.busy);
    end
    send_cmd(16'h2345, 1'b0, hi, lo, lat, bok, fok);
    clear_mon();
    send_byte(8'hA5, 1'b0);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL ferr_cnt got %0d want 1", err_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL ferr_done got %0d want 0", done_cnt); end
    checks++; if (cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL ferr_busy got %b want 0", cmd_if.busy);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] hi, lo; int lat; bit bok, fok;
    send_cmd(16'h2345, 1'b1, hi, lo, lat, bok, fok);
    checks++; if (hi !== 8'h23) begin errors++; $display("FAIL ign_hi got %h want 23", hi); end
    checks++; if (lo !== 8'h45) begin errors++; $display("FAIL ign_lo got %h want 45", lo); end
    checks++; if (lat != 320) begin errors++; $display("FAIL ign_lat got %0d want 320", lat); end
    send_byte(8'hA5, 1'b1);
    checks++; if (cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL ign_busy got %b want 0", cmd_if.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] hi, lo; int lat; bit bok, fok;
    @(negedge clk);
    cmd_if.snd_cmd = 1'b1; cmd_if.cmd = 16'h2345;
    @(negedge clk);
    cmd_if.snd_cmd = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", TX); end
    checks++; if (cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy got %b want 0", cmd_if.busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_cmd(16'hA51C, 1'b0, hi, lo, lat, bok, fok);
    checks++; if (hi !== 8'hA5) begin errors++; $display("FAIL post_hi got %h want a5", hi); end
    checks++; if (lo !== 8'h1C) begin errors++; $display("FAIL post_lo got %h want 1c", lo); end
    checks++; if (!fok || lat != 320) begin
      errors++; $display("FAIL post_frame got fok=%b lat=%0d want fok=1 lat=320", fok, lat);
    end
    send_byte(8'hA5, 1'b1);
  endtask

  task automatic test_timeout();
    logic [7:0] hi, lo; int lat; bit bok, fok;
    send_cmd(16'h0F0F, 1'b0, hi, lo, lat, bok, fok);
    clear_mon();
`ifdef REMOTE_TMO_EN
    begin
      int n;
      n = 0;
      while (n < 1100 && !cmd_if.tmo) begin
        @(negedge clk);
        n++;
      end
      checks++; if (n != 1000) begin errors++; $display("FAIL tmo_lat got %0d want 1000", n); end
      @(negedge clk);
      checks++; if (cmd_if.busy !== 1'b0) begin
        errors++; $display("FAIL tmo_busy got %b want 0", cmd_if.busy);
      end
    end
`else
    repeat (1200) @(negedge clk);
    checks++; if (tmo_cnt != 0) begin errors++; $display("FAIL no_tmo got %0d want 0", tmo_cnt); end
    checks++; if (cmd_if.busy !== 1'b1) begin
      errors++; $display("FAIL no_tmo_busy got %b want 1", cmd_if.busy);
    end
    send_byte(8'hA5, 1'b1);
    checks++; if (cmd_if.busy !== 1'b0) begin
      errors++; $display("FAIL no_tmo_done got %b want 0", cmd_if.busy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cmd_frame();
    test_responses();
    test_bad_resp();
    test_busy_ignore();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
